click_input: RTL and testbench



---
 rtl/super4_pkg.sv | 7 +
 rtl/click_debounce.sv | 46 ++++
 rtl/click_input.sv | 64 ++++++
 tb/tb_click_input.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/super4_pkg.sv
// Shared types for the super4 player blocks (click_input, game).
package super4_pkg;
  localparam int NUM_PLAYERS = 4;

  typedef logic [1:0]             player_t;
  typedef logic [NUM_PLAYERS-1:0] click_vec_t;
endpackage

// File: rtl/click_debounce.sv
// One button channel: 2-flop synchronizer, run-length debouncer and a rise
// strobe that fires on the cycle whose clock edge sets `stable`.
module click_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic stable,
  output logic rise
);
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_bad_param
    $error("click_debounce: DEBOUNCE_CYCLES must be in 2..255");
  end

  localparam logic [7:0] LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic       sync1, btn_s;
  logic [7:0] cnt;
  logic       flip;

  // Accepting the D-th differing sample; the flop update and the strobe
  // are both derived from this so click and held move on the same edge.
  assign flip = (btn_s != stable) && (cnt == LAST);
  assign rise = flip && !stable;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b0;
      btn_s  <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync1 <= btn;
      btn_s <= sync1;
      if (btn_s == stable) begin
        cnt <= '0;
      end else if (flip) begin
        stable <= ~stable;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end
endmodule

// File: rtl/click_input.sv
// Button front end for game: sync + debounce per player, press -> click pulse.
// Define CLICK_ARB_EN to serialize simultaneous presses round-robin (one-hot).
module click_input
  import super4_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  output logic [3:0] click,
  output logic [3:0] held
);
  click_vec_t rise;

  for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_ch
    click_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn[i]),
      .stable(held[i]),
      .rise  (rise[i])
    );
  end

`ifdef CLICK_ARB_EN
  click_vec_t pending, pending_nxt, grant;
  player_t    ptr, ptr_nxt, idx;

  // First pending bit at or after ptr wins; a same-cycle rise re-arms it.
  always_comb begin
    grant   = '0;
    ptr_nxt = ptr;
    idx     = ptr;
    for (int k = 0; k < NUM_PLAYERS; k++) begin
      idx = ptr + player_t'(k);
      if (grant == '0 && pending[idx]) begin
        grant[idx] = 1'b1;
        ptr_nxt    = idx + player_t'(1);
      end
    end
    pending_nxt = (pending & ~grant) | rise;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      ptr     <= '0;
      click   <= '0;
    end else begin
      pending <= pending_nxt;
      ptr     <= ptr_nxt;
      click   <= grant;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) click <= '0;
    else     click <= rise;
  end
`endif
endmodule

// File: tb/tb_click_input.sv
// Self-checking bench for click_input against a window-based behavioural model.
module tb_click_input;
  localparam int D = 4;
`ifdef CLICK_ARB_EN
  localparam int LAT = D + 3;
`else
  localparam int LAT = D + 2;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;
  logic [3:0] click, held;

  click_input #(.DEBOUNCE_CYCLES(D)) dut (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn),
    .click(click),
    .held (held)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Model: a press/release is accepted once the last D synchronized samples
  // all disagree with the accepted level.
  logic [255:0] hist[4];
  logic [3:0]   m_s1, m_bs, m_stable, m_click, m_pend;
  int           m_ptr;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) hist[i] = '0;
    m_s1 = '0; m_bs = '0; m_stable = '0; m_click = '0; m_pend = '0; m_ptr = 0;
  endtask

  task automatic model_step(input logic [3:0] b);
    logic [3:0] rise;
    logic       all_diff;
    int         win;
    rise = '0;
    for (int i = 0; i < 4; i++) begin
      hist[i] = {hist[i][254:0], m_bs[i]};
      all_diff = 1'b1;
      for (int j = 0; j < D; j++) if (hist[i][j] == m_stable[i]) all_diff = 1'b0;
      if (all_diff) begin
        m_stable[i] = ~m_stable[i];
        if (m_stable[i]) rise[i] = 1'b1;
      end
    end
`ifdef CLICK_ARB_EN
    win = -1;
    for (int k = 0; k < 4; k++)
      if (win < 0 && m_pend[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
    m_click = '0;
    if (win >= 0) begin
      m_click[win] = 1'b1;
      m_pend[win]  = 1'b0;
      m_ptr        = (win + 1) % 4;
    end
    m_pend = m_pend | rise;
`else
    m_click = rise;
`endif
    m_bs = m_s1;
    m_s1 = b;
  endtask

  // Called at a negedge: apply b, advance one clock, compare at next negedge.
  task automatic tick(input logic [3:0] b);
    btn = b;
    if (rst) model_reset();
    else     model_step(b);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    chk("click", {28'd0, click}, {28'd0, m_click});
    chk("held",  {28'd0, held},  {28'd0, m_stable});
`ifdef CLICK_ARB_EN
    chk("onehot", {31'd0, $countones(click) <= 1}, 32'd1);
`endif
  endtask

  task automatic do_reset(input logic [3:0] b, input int n);
    btn = b;
    rst = 1'b1;
    #1;
    chk("rst_click", {28'd0, click}, 32'd0);
    chk("rst_held",  {28'd0, held},  32'd0);
    model_reset();
    for (int k = 0; k < n; k++) tick(b);
    rst = 1'b0;
  endtask

  task automatic wait_click(input logic [3:0] b, input int budget,
                            output int lat, output logic [3:0] v);
    lat = -1;
    v   = '0;
    for (int k = 1; k <= budget; k++) begin
      tick(b);
      if (click != 4'd0) begin
        lat = k;
        v   = click;
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(4'd0);
  endtask

  task automatic chk_order(input string tag, input logic [15:0] seq);
    int         lat;
    logic [3:0] v;
    logic [3:0] e;
    wait_click(4'hF, 20, lat, v);
    chk({tag, "_lat"}, lat, LAT);
    e = seq[3:0];
    chk({tag, "_0"}, {28'd0, v}, {28'd0, e});
    for (int k = 1; k < 4; k++) begin
      tick(4'hF);
      e = seq[4*k +: 4];
      chk($sformatf("%s_%0d", tag, k), {28'd0, click}, {28'd0, e});
    end
  endtask

  int         lat, rel;
  logic [3:0] v, b, prev;
  int         n_click[4], n_rise[4];
  int         periods[4] = '{60, 80, 100, 130};

  initial begin
    rst = 1'b1;
    btn = '0;
    model_reset();
    @(negedge clk);

    // reset with all buttons held: fresh press after release
    do_reset(4'hF, 3);
`ifdef CLICK_ARB_EN
    chk_order("rst_arb", 16'h8421);
`else
    wait_click(4'hF, 20, lat, v);
    chk("rst_lat", lat, LAT);
    chk("rst_click4", {28'd0, v}, 32'hF);
`endif
    idle(20);

    // single press on player 2, then release
    wait_click(4'b0100, 20, lat, v);
    chk("single_lat", lat, LAT);
    chk("single_val", {28'd0, v}, 32'h4);
    for (int k = lat; k < 20; k++) tick(4'b0100);
    rel = -1;
    for (int k = 1; k <= 20; k++) begin
      tick(4'd0);
      if (!held[2]) begin rel = k; break; end
    end
    chk("release_lat", rel, D + 2);
    idle(15);

    // glitches of 3 and 1 samples on player 0
    for (int k = 0; k < 3; k++) tick(4'b0001);
    idle(2);
    tick(4'b0001);
    idle(20);
    chk("glitch_held", {28'd0, held}, 32'd0);

    // bounce on player 1, then held high
    for (int k = 0; k < 10; k++) tick((k % 2 == 0) ? 4'b0010 : 4'b0000);
    wait_click(4'b0010, 20, lat, v);
    chk("bounce_lat", lat, LAT);
    chk("bounce_val", {28'd0, v}, 32'h2);
    for (int k = 0; k < 10; k++) tick(4'b0010);
    idle(20);

`ifdef CLICK_ARB_EN
    // move the pointer to 2 with a lone press on player 1
    do_reset(4'd0, 2);
    wait_click(4'b0010, 20, lat, v);
    chk("ptr_lat", lat, LAT);
    tick(4'b0010);
    idle(20);
    chk_order("ptr2_arb", 16'h2184);
    idle(20);
`endif

    // random bouncy stimulus with one mid-run reset
    b = '0;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(7) == 0) b[i] = ~b[i];
      if (k == 1500) do_reset(b, 2);
      tick(b);
    end
    idle(20);

    // long run: square waves, every rise must yield exactly one click
    do_reset(4'd0, 2);
    for (int i = 0; i < 4; i++) begin n_click[i] = 0; n_rise[i] = 0; end
    prev = '0;
    for (int k = 0; k < 20000; k++) begin
      for (int i = 0; i < 4; i++) b[i] = (k % periods[i]) >= (periods[i] / 2);
      for (int i = 0; i < 4; i++) if (b[i] && !prev[i]) n_rise[i]++;
      prev = b;
      tick(b);
      for (int i = 0; i < 4; i++) if (click[i]) n_click[i]++;
    end
    for (int k = 0; k < 30; k++) begin
      tick(4'd0);
      for (int i = 0; i < 4; i++) if (click[i]) n_click[i]++;
    end
    for (int i = 0; i < 4; i++) chk($sformatf("pulses_ch%0d", i), n_click[i], n_rise[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
